// File: rtl/rs232_pkg.sv
// Shared definitions for the buffered RS232 peripheral: register indices,
// STATUS bit layout and TX drain FSM encoding.
package rs232_pkg;

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_TXDATA = 3'd2;
  localparam logic [2:0] REG_TSC    = 3'd3;
  localparam logic [2:0] REG_IRQEN  = 3'd4;
  localparam logic [2:0] REG_CLR    = 3'd5;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_RX_NONEMPTY  = 1;
  localparam int ST_RX_OVERRUN   = 2;
  localparam int ST_TX_EMPTY     = 3;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  localparam int CLR_OVERRUN_BIT = 2;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_e;

  function automatic logic [31:0] pack_status(
    input logic       tx_full,
    input logic       rx_nonempty,
    input logic       rx_overrun,
    input logic       tx_empty,
    input logic [7:0] rx_count,
    input logic [7:0] tx_count
  );
    logic [31:0] s;
    s                          = '0;
    s[ST_TX_FULL]              = tx_full;
    s[ST_RX_NONEMPTY]          = rx_nonempty;
    s[ST_RX_OVERRUN]           = rx_overrun;
    s[ST_TX_EMPTY]             = tx_empty;
    s[ST_RX_COUNT_LSB +: 8]    = rx_count;
    s[ST_TX_COUNT_LSB +: 8]    = tx_count;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an AW+1 bit occupancy count; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int AW = 4,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [AW:0]  count_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_pop;
  logic          do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rs232_buffered.sv
// Bus-mapped RS232 front end: RX/TX FIFOs, TX drain FSM, free-running TSC
// and a level interrupt built from maskable status bits.
//
// state   | meaning
// TX_IDLE | waiting for a queued byte and an idle transmitter
// TX_SEND | one-cycle strobe of the head byte, head popped
// TX_GAP  | one dead cycle so the UART can raise busy
module rs232_buffered
  import rs232_pkg::*;
#(
  parameter int RX_AW = 4,
  parameter int TX_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_hold,
  input  logic        rs232in_attention,
  input  logic [7:0]  rs232in_data,
  input  logic        rs232out_busy,
  output logic        rs232out_w,
  output logic [7:0]  rs232out_d,
  output logic        irq
);

  logic [2:0]     reg_idx;
  logic           rx_pop, rx_full, rx_empty;
  logic [7:0]     rx_head;
  logic [RX_AW:0] rx_count;
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]     tx_head;
  logic [TX_AW:0] tx_count;
  logic           clr_hit, rx_drop;
  logic           overrun_q, overrun_d;
  logic [2:0]     irqen_q;
  logic [31:0]    tsc_q;
  logic [31:0]    rdata_q, rdata_d;
  logic           irq_q, irq_d;
  logic [31:0]    status;
  tx_state_e      state_q, state_d;
  logic           unused_bits;

  assign reg_idx     = bus_addr[4:2];
  assign unused_bits = ^{bus_addr[31:5], bus_addr[1:0], bus_wdata[31:8]};
  assign bus_hold    = 1'b0;
  assign bus_rdata   = rdata_q;
  assign irq         = irq_q;

  assign rx_pop  = bus_rd & (reg_idx == REG_RXDATA) & ~rx_empty;
  assign rx_drop = rs232in_attention & rx_full & ~rx_pop;
  assign tx_push = bus_wr & (reg_idx == REG_TXDATA);
  assign clr_hit = bus_wr & (reg_idx == REG_CLR) & bus_wdata[CLR_OVERRUN_BIT];
  // A fresh overrun in the same cycle as a clear keeps the flag set.
  assign overrun_d = rx_drop | (overrun_q & ~clr_hit);

  sync_fifo #(.AW(RX_AW), .W(8)) u_rx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rs232in_attention),
    .push_data_i (rs232in_data),
    .pop_i       (rx_pop),
    .head_o      (rx_head),
    .count_o     (rx_count),
    .full_o      (rx_full),
    .empty_o     (rx_empty)
  );

  sync_fifo #(.AW(TX_AW), .W(8)) u_tx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (tx_push),
    .push_data_i (bus_wdata[7:0]),
    .pop_i       (tx_pop),
    .head_o      (tx_head),
    .count_o     (tx_count),
    .full_o      (tx_full),
    .empty_o     (tx_empty)
  );

  always_comb begin
    state_d    = state_q;
    tx_pop     = 1'b0;
    rs232out_w = 1'b0;
    rs232out_d = 8'h00;
    case (state_q)
      TX_IDLE: if (!tx_empty && !rs232out_busy) state_d = TX_SEND;
      TX_SEND: begin
        rs232out_w = 1'b1;
        rs232out_d = tx_head;
        tx_pop     = ~rst;
        state_d    = TX_GAP;
      end
      TX_GAP:  state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  assign status = pack_status(tx_full, ~rx_empty, overrun_q, tx_empty,
                              8'(rx_count), 8'(tx_count));

  always_comb begin
    rdata_d = '0;
    if (bus_rd) begin
      case (reg_idx)
        REG_STATUS: rdata_d = status;
        REG_RXDATA: rdata_d = rx_empty ? 32'd0 : {24'd0, rx_head};
        REG_TSC:    rdata_d = tsc_q;
        REG_IRQEN:  rdata_d = {29'd0, irqen_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  assign irq_d = (~rx_empty & irqen_q[0]) | (tx_empty & irqen_q[1]) |
                 (overrun_q & irqen_q[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      overrun_q <= 1'b0;
      irqen_q   <= '0;
      tsc_q     <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= overrun_d;
      if (bus_wr && reg_idx == REG_IRQEN) irqen_q <= bus_wdata[2:0];
      tsc_q     <= tsc_q + 32'd1;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: doc/rs232_buffered.md
RS232_BUFFERED -- requirements
Module: rs232_buffered

Interface
REQ-001 SHALL have parameter RX_AW, default 4, meaning log2 of the RX FIFO depth (16 entries).
REQ-002 SHALL have parameter TX_AW, default 4, meaning log2 of the TX FIFO depth (16 entries).
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port bus_addr, input, 32, byte address; only bits [4:2] decoded.
REQ-006 SHALL have port bus_rd, input, 1, read strobe.
REQ-007 SHALL have port bus_wr, input, 1, write strobe.
REQ-008 SHALL have port bus_wdata, input, 32, write data.
REQ-009 SHALL have port bus_rdata, output, 32, registered read data.
REQ-010 SHALL have port bus_hold, output, 1, tied 0.
REQ-011 SHALL have port rs232in_attention, input, 1, one-cycle pulse meaning a received byte is valid.
REQ-012 SHALL have port rs232in_data, input, 8, received byte.
REQ-013 SHALL have port rs232out_busy, input, 1, transmitter busy.
REQ-014 SHALL have port rs232out_w, output, 1, transmit strobe.
REQ-015 SHALL have port rs232out_d, output, 8, transmit byte.
REQ-016 SHALL have port irq, output, 1, registered interrupt request.

Function
REQ-017 SHALL use the register map indexed by bus_addr[4:2]:
- 0 STATUS (R): bit0 tx_full; bit1 rx_nonempty; bit2 rx_overrun; bit3 tx_empty; [15:8] rx_count; [23:16] tx_count.
- 1 RXDATA (R): pop.
- 2 TXDATA (W): push wdata[7:0].
- 3 TSC (R): counter.
- 4 IRQEN (R/W): bits[2:0].
- 5 CLR (W): wdata bit2 clears overrun.
REQ-018 SHALL return read data on bus_rdata one cycle after bus_rd, and drive 0 in every cycle without a read or for an unmapped index (6, 7).
REQ-019 SHALL, on an RXDATA read with the RX FIFO non-empty, return the head byte zero-extended and pop it; if the FIFO is empty SHALL return 0 with no pop.
REQ-020 SHALL push rs232in_data on rs232in_attention; if the FIFO is full and no pop occurs that cycle, the byte SHALL be dropped and rx_overrun set (sticky).
REQ-021 SHALL, when a pop and a push occur in the same cycle on a full RX FIFO, accept both, leave the count unchanged, and not set overrun.
REQ-022 SHALL silently drop a TXDATA write when the TX FIFO is full and no drain occurs that cycle.
REQ-023 SHALL run the TX drain FSM with states IDLE, SEND, GAP:
- IDLE->SEND when TX non-empty and !rs232out_busy.
- SEND asserts rs232out_w for exactly one cycle with rs232out_d = head byte, pops, then goes to GAP.
- GAP->IDLE after one cycle, giving the UART time to raise busy.
REQ-024 SHALL drive rs232out_d = 0 outside SEND.
REQ-025 SHALL hold a 32-bit TSC that increments every cycle and wraps from FFFFFFFF to 0.
REQ-026 SHALL compute irq next = (rx_nonempty & en[0]) | (tx_empty & en[1]) | (rx_overrun & en[2]).
REQ-027 SHALL, when CLR is written with bit2 in the same cycle a new overrun occurs, leave overrun set (set wins).
REQ-028 SHALL use counts of width AW+1 so that full is distinct from empty.

Reset
REQ-029 SHALL, on rst, set empty both FIFOs, set TSC = 0, overrun = 0, IRQEN = 0, bus_rdata = 0, irq = 0, rs232out_w = 0, and FSM = IDLE.
REQ-030 SHALL, on rst asserted during SEND, abort the send and not pop the byte, with rs232out_w low in the following cycle.

Structure
REQ-031 SHALL define register indices, STATUS bit positions and FSM state encodings in the shared package rs232_pkg.
REQ-032 SHALL instantiate two copies of a sub-module sync_fifo(AW, W=8) providing push, pop, head, count, full, empty, with simultaneous push and pop allowed when full.

Verification
REQ-033 SHALL verify: write 0x41 and 0x42 to TXDATA with busy=0 -> two rs232out_w pulses carrying 41 then 42, at least 3 cycles apart.
REQ-034 SHALL verify: 17 attention pulses with no reads -> STATUS rx_count=16 and overrun=1; an RXDATA read returns the first byte.
REQ-035 SHALL verify: RX full, with attention and an RXDATA read in the same cycle -> count stays 16 and overrun stays 0.
REQ-036 SHALL verify: IRQEN=1 and one byte received -> irq=1; after an RXDATA read, irq=0 within 2 cycles.
REQ-037 SHALL verify: RXDATA read while empty -> 0; TSC read twice N cycles apart -> values differ by N.
REQ-038 SHALL verify: rst asserted mid-SEND -> rs232out_w low on the next cycle, STATUS reads tx_empty=1, rx_count=0.
